// File: rtl/sobel_window_ctrl.sv
// Line-buffer sequencer for the 3x3 Sobel engine: buffers a raster pixel stream in four line
// buffers and emits packed 3x3 windows. Optional frame counting: SOBEL_WINDOW_CTRL_FRAME_CNT_EN.
module sobel_window_ctrl #(
`ifdef SOBEL_WINDOW_CTRL_FRAME_CNT_EN
    parameter int IMG_HEIGHT = 512,
`endif
    parameter int IMG_WIDTH  = 512,
    parameter int NUM_LB     = 4
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic [7:0]  i_pixel_data,
    input  logic        i_pixel_data_valid,
    output logic [71:0] o_pixel_data,
    output logic        o_pixel_data_valid,
    output logic        o_intr,
`ifdef SOBEL_WINDOW_CTRL_FRAME_CNT_EN
    output logic        o_frame_done,
`endif
    output logic        o_overflow
);

    localparam int PW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int CW = $clog2(4 * IMG_WIDTH + 1);
    localparam logic [PW-1:0] PTR_LAST  = PW'(IMG_WIDTH - 1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(4 * IMG_WIDTH);
    localparam logic [CW-1:0] CNT_START = CW'(3 * IMG_WIDTH);
    localparam logic [CW-1:0] CNT_LINE  = CW'(IMG_WIDTH);

    typedef enum logic {IDLE = 1'b0, READ = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [1:0]      wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_q, ovf_d;
    logic [71:0]     pix_q;
    logic            vld_q, intr_q;
    logic            accept, eol, rd_en;
    logic [71:0]     window;
    logic [1:0]      row_sel;
    logic [PW:0]     col;
    logic [7:0]      lb_mem [NUM_LB][IMG_WIDTH];

`ifdef SOBEL_WINDOW_CTRL_FRAME_CNT_EN
    localparam int LW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [LW-1:0] LINE_LAST = LW'(IMG_HEIGHT - 3);
    logic [LW-1:0] line_cnt_q, line_cnt_d;
    logic          frame_q, frame_last;

    assign frame_last = eol && (line_cnt_q == LINE_LAST);
    assign line_cnt_d = frame_last ? '0 : (eol ? line_cnt_q + LW'(1) : line_cnt_q);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            line_cnt_q <= '0;
            frame_q    <= 1'b0;
        end else begin
            line_cnt_q <= line_cnt_d;
            frame_q    <= frame_last;
        end
    end

    assign o_frame_done = frame_q;
`endif

    assign accept = i_pixel_data_valid && (count_q < CNT_FULL);
    assign eol    = rd_en && (rd_ptr_q == PTR_LAST);

    // Line buffer RAM is deliberately left out of reset.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            lb_mem[wr_sel_q][wr_ptr_q] <= i_pixel_data;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        wr_sel_d = wr_sel_q;
        rd_ptr_d = rd_ptr_q;
        rd_sel_d = rd_sel_q;
        count_d  = count_q + CW'(accept) - (eol ? CNT_LINE : '0);
        ovf_d    = ovf_q | (i_pixel_data_valid & ~accept);
        if (accept) begin
            if (wr_ptr_q == PTR_LAST) begin
                wr_ptr_d = '0;
                wr_sel_d = wr_sel_q + 2'd1;
            end else begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
        end
        if (rd_en) begin
            if (eol) begin
                rd_ptr_d = '0;
                rd_sel_d = rd_sel_q + 2'd1;
            end else begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
        end
`ifdef SOBEL_WINDOW_CTRL_FRAME_CNT_EN
        if (frame_last) begin
            wr_ptr_d = '0;
            wr_sel_d = '0;
            rd_ptr_d = '0;
            rd_sel_d = '0;
            count_d  = '0;
        end
`endif
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Continue straight into the next line when the updated count already holds three lines.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (count_q >= CNT_START) state_d = READ;
            READ: if (eol && (count_d < CNT_START)) state_d = IDLE;
        endcase
`ifdef SOBEL_WINDOW_CTRL_FRAME_CNT_EN
        if (frame_last) state_d = IDLE;
`endif
    end

    always_comb begin
        rd_en = (state_q == READ);
    end

    // Right-edge columns replicate the last pixel of the line.
    always_comb begin
        window  = '0;
        row_sel = '0;
        col     = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                row_sel = rd_sel_q + 2'(r);
                col     = {1'b0, rd_ptr_q} + (PW+1)'(c);
                if (col > {1'b0, PTR_LAST}) col = {1'b0, PTR_LAST};
                window[(r*3+c)*8 +: 8] = lb_mem[row_sel][col[PW-1:0]];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wr_ptr_q <= '0;
            wr_sel_q <= '0;
            rd_ptr_q <= '0;
            rd_sel_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            pix_q    <= '0;
            vld_q    <= 1'b0;
            intr_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            wr_sel_q <= wr_sel_d;
            rd_ptr_q <= rd_ptr_d;
            rd_sel_q <= rd_sel_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            vld_q    <= rd_en;
            intr_q   <= eol;
            if (rd_en) pix_q <= window;
        end
    end

    assign o_pixel_data       = pix_q;
    assign o_pixel_data_valid = vld_q;
    assign o_intr             = intr_q;
    assign o_overflow         = ovf_q;

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Self-checking bench for sobel_window_ctrl (IMG_WIDTH=8): window scoreboard built from the
// pixel stream, table of hand-derived windows, and sequences for overflow/abort corner cases.
module tb_sobel_window_ctrl;

    localparam int W = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  din;
    logic        dv;
    logic [71:0] dout;
    logic        vld, intr, ovf;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    sobel_window_ctrl #(.IMG_WIDTH(W), .NUM_LB(4)) dut (
        .i_clk              (clk),
        .i_rstn             (rst_n),
        .i_pixel_data       (din),
        .i_pixel_data_valid (dv),
        .o_pixel_data       (dout),
        .o_pixel_data_valid (vld),
        .o_intr             (intr),
        .o_overflow         (ovf)
    );

    typedef struct {
        int          scen;
        int          win;
        logic [71:0] wexp;
        string       name;
    } vec_t;
    vec_t tbl[6];

    int n_checks = 0;
    int n_err    = 0;
    int n_vld, n_intr, first_cyc, last_cyc, intr_cyc;
    logic [71:0] sb[$];
    logic [71:0] cap[$];
    logic [7:0]  strm[$];

    function automatic void check_w(input string nm, input logic [71:0] act, input logic [71:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%h required=%h", nm, act, req);
        end
    endfunction

    function automatic void check_i(input string nm, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: actual=%0d required=%0d", nm, act, req);
        end
    endfunction

    // Expected windows for output line L come from stream lines L..L+2.
    function automatic void model_push(input logic [7:0] v);
        int L, col;
        logic [71:0] w;
        strm.push_back(v);
        if ((strm.size() % W == 0) && (strm.size() >= 3 * W)) begin
            L = strm.size() / W - 3;
            for (int c = 0; c < W; c++) begin
                w = '0;
                for (int r = 0; r < 3; r++) begin
                    for (int k = 0; k < 3; k++) begin
                        col = (c + k > W - 1) ? W - 1 : c + k;
                        w[(r*3+k)*8 +: 8] = strm[(L + r) * W + col];
                    end
                end
                sb.push_back(w);
            end
        end
    endfunction

    always @(negedge clk) begin
        logic [71:0] wexp;
        if (rst_n === 1'b1) begin
            if (vld === 1'b1) begin
                cap.push_back(dout);
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                n_vld++;
                if (sb.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL sb_unexpected: actual=%h required=no window", dout);
                end else begin
                    wexp = sb.pop_front();
                    check_w("sb_window", dout, wexp);
                end
            end
            if (intr === 1'b1) begin
                n_intr++;
                intr_cyc = cyc;
            end
        end
    end

    task automatic clear_model();
        sb.delete();
        cap.delete();
        strm.delete();
        n_vld = 0;
        n_intr = 0;
        first_cyc = -1;
        last_cyc = -1;
        intr_cyc = -1;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        dv = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_model();
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input bit model);
        @(negedge clk);
        dv = v;
        din = d;
        if (v && model) model_push(d);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            dv = 1'b0;
        end
    endtask

    task automatic check_table(input int scen);
        for (int i = 0; i < 6; i++) begin
            if (tbl[i].scen == scen) begin
                if (tbl[i].win < cap.size()) check_w(tbl[i].name, cap[tbl[i].win], tbl[i].wexp);
                else check_i({tbl[i].name, "_missing"}, cap.size(), tbl[i].win + 1);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: actual=no finish required=finish");
        $fatal(1, "timeout");
    end

    initial begin
        int t23;
        rst_n = 1'b0;
        din = '0;
        dv = 1'b0;
        clear_model();
        tbl[0] = '{0, 0, {8'd18, 8'd17, 8'd16, 8'd10, 8'd9, 8'd8, 8'd2, 8'd1, 8'd0}, "fill_w0"};
        tbl[1] = '{0, 3, {8'd21, 8'd20, 8'd19, 8'd13, 8'd12, 8'd11, 8'd5, 8'd4, 8'd3}, "fill_w3"};
        tbl[2] = '{0, 6, {8'd23, 8'd23, 8'd22, 8'd15, 8'd15, 8'd14, 8'd7, 8'd7, 8'd6}, "fill_w6"};
        tbl[3] = '{0, 7, {8'd23, 8'd23, 8'd23, 8'd15, 8'd15, 8'd15, 8'd7, 8'd7, 8'd7}, "fill_w7"};
        tbl[4] = '{1, 0, {8'd168, 8'd167, 8'd166, 8'd160, 8'd159, 8'd158, 8'd152, 8'd151, 8'd150}, "rearm_w0"};
        tbl[5] = '{1, 7, {8'd173, 8'd173, 8'd173, 8'd165, 8'd165, 8'd165, 8'd157, 8'd157, 8'd157}, "rearm_w7"};

        // Reset held with random inputs, then idle after release.
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            din = 8'($urandom);
            dv = 1'($urandom);
            #1;
            check_w("rst_data", dout, '0);
            check_i("rst_ctrl", int'({vld, intr, ovf}), 0);
        end
        @(negedge clk);
        dv = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            check_w("idle_data", dout, '0);
            check_i("idle_ctrl", int'({vld, intr, ovf}), 0);
        end

        // Fill three lines and read the first window line.
        reset_dut();
        for (int i = 0; i < 24; i++) drive(1'b1, 8'(i), 1'b1);
        t23 = cyc;
        idle(30);
        check_i("fill_latency", first_cyc - t23, 3);
        check_i("fill_valids", n_vld, 8);
        check_i("fill_intr", n_intr, 1);
        check_i("fill_intr_last", intr_cyc, last_cyc);
        check_i("fill_sb_drained", sb.size(), 0);
        check_i("fill_ovf", int'(ovf), 0);
        check_w("fill_hold", dout, tbl[3].wexp);
        check_table(0);

        // Half-rate stream of six lines, exercising buffer rotation.
        reset_dut();
        for (int i = 0; i < 48; i++) begin
            drive(1'b1, 8'(i * 7 + 3), 1'b1);
            drive(1'b0, 8'd0, 1'b0);
        end
        idle(30);
        check_i("cont_valids", n_vld, 32);
        check_i("cont_intr", n_intr, 4);
        check_i("cont_ovf", int'(ovf), 0);
        check_i("cont_sb_drained", sb.size(), 0);

        // Pixel accepted on the end-of-line cycle keeps the read running without a gap.
        reset_dut();
        for (int i = 0; i < 31; i++) drive(1'b1, 8'(i + 40), 1'b1);
        drive(1'b0, 8'd0, 1'b0);
        drive(1'b1, 8'd71, 1'b1);
        idle(30);
        check_i("simul_valids", n_vld, 16);
        check_i("simul_intr", n_intr, 2);
        check_i("simul_contiguous", last_cyc - first_cyc, 15);
        check_i("simul_sb_drained", sb.size(), 0);
        check_i("simul_ovf", int'(ovf), 0);

        // Back-to-back burst: the 33rd pixel finds all buffers full and is dropped.
        reset_dut();
        for (int i = 0; i < 32; i++) drive(1'b1, 8'(i + 90), 1'b1);
        drive(1'b1, 8'd122, 1'b0);
        #1;
        check_i("ovf_before_drop", int'(ovf), 0);
        idle(1);
        #1;
        check_i("ovf_after_drop", int'(ovf), 1);
        idle(30);
        check_i("ovf_sticky", int'(ovf), 1);
        check_i("ovf_valids", n_vld, 16);
        check_i("ovf_intr", n_intr, 2);
        check_i("ovf_sb_drained", sb.size(), 0);

        // Reset during window 4 aborts the line; a fresh fill restarts cleanly.
        reset_dut();
        for (int i = 0; i < 24; i++) drive(1'b1, 8'(i + 10), 1'b1);
        idle(1);
        for (int k = 0; k < 40 && n_vld < 5; k++) begin
            @(negedge clk);
            #1;
        end
        check_i("mid_win4_seen", n_vld, 5);
        rst_n = 1'b0;
        #1;
        check_i("mid_async_ctrl", int'({vld, intr}), 0);
        check_w("mid_async_data", dout, '0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        clear_model();
        for (int i = 0; i < 24; i++) drive(1'b1, 8'(i + 150), 1'b1);
        idle(30);
        check_i("rearm_valids", n_vld, 8);
        check_i("rearm_intr", n_intr, 1);
        check_i("rearm_sb_drained", sb.size(), 0);
        check_i("rearm_ovf", int'(ovf), 0);
        check_table(1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
